// File: rtl/contention_arbiter_n.sv
// contention_arbiter_n: grants the fullest pixel FIFO and forwards one pixel per grant to the Z-buffer.
// Optional CT_RR_TIEBREAK_EN: round-robin tie-break among max-fill channels. Rev 1.0
`default_nettype none

module contention_arbiter_n #(
  parameter int NUM_CH         = 4,
  parameter int FILL_WIDTH     = 8,
  parameter int PIXEL_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] pix_in,
  input  logic [NUM_CH*FILL_WIDTH-1:0]  fill,
  input  logic [NUM_CH-1:0]             ack,
  input  logic                          rdy_z_buffer,
  output logic [NUM_CH-1:0]             req,
  output logic                          send_z_buffer,
  output logic [PIXEL_WIDTH-1:0]        pix_out,
  output logic [$clog2(NUM_CH)-1:0]     grant_id
);

  localparam int GW   = $clog2(NUM_CH);
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMAX = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TLAST = TMAX[CW-1:0];

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HARVEST = 2'd1;
  localparam logic [1:0] S_SEND    = 2'd2;
  localparam logic [1:0] S_WAIT    = 2'd3;

  logic [1:0]             state, state_nxt;
  logic [CW-1:0]          tcnt, tcnt_nxt;
  logic [NUM_CH-1:0]      req_nxt;
  logic                   send_nxt;
  logic [PIXEL_WIDTH-1:0] pix_nxt;
  logic [GW-1:0]          gid_nxt;
  logic [GW-1:0]          sel;
  logic [FILL_WIDTH-1:0]  best_fill;
  logic                   any_fill;
  logic                   ack_g;
  logic                   timeout_hit;

`ifdef CT_RR_TIEBREAK_EN
  logic [GW-1:0] last_served, last_nxt;
  int            rr_idx;

  // Scan starts just after the last served channel so equal fills rotate.
  always_comb begin
    sel       = '0;
    best_fill = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_idx = (int'(last_served) + 1 + k) % NUM_CH;
      if (k == 0 || fill[rr_idx*FILL_WIDTH +: FILL_WIDTH] > best_fill) begin
        best_fill = fill[rr_idx*FILL_WIDTH +: FILL_WIDTH];
        sel       = GW'(rr_idx);
      end
    end
  end
`else
  always_comb begin
    sel       = '0;
    best_fill = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i == 0 || fill[i*FILL_WIDTH +: FILL_WIDTH] > best_fill) begin
        best_fill = fill[i*FILL_WIDTH +: FILL_WIDTH];
        sel       = GW'(i);
      end
    end
  end
`endif

  assign any_fill    = |fill;
  assign ack_g       = ack[grant_id];
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      req           <= '0;
      send_z_buffer <= 1'b0;
      pix_out       <= '0;
      grant_id      <= '0;
`ifdef CT_RR_TIEBREAK_EN
      last_served   <= GW'(NUM_CH - 1);
`endif
    end else begin
      state         <= state_nxt;
      tcnt          <= tcnt_nxt;
      req           <= req_nxt;
      send_z_buffer <= send_nxt;
      pix_out       <= pix_nxt;
      grant_id      <= gid_nxt;
`ifdef CT_RR_TIEBREAK_EN
      last_served   <= last_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (rdy_z_buffer) state_nxt = S_HARVEST;
      S_HARVEST: begin
        if (!rdy_z_buffer) state_nxt = S_IDLE;
        else if (any_fill) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (ack_g)            state_nxt = S_WAIT;
        else if (timeout_hit) state_nxt = S_HARVEST;
      end
      S_WAIT:    if (!rdy_z_buffer) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ack takes priority over timeout.
  always_comb begin
    req_nxt  = req;
    send_nxt = send_z_buffer;
    pix_nxt  = pix_out;
    gid_nxt  = grant_id;
    tcnt_nxt = tcnt;
`ifdef CT_RR_TIEBREAK_EN
    last_nxt = last_served;
`endif
    case (state)
      S_HARVEST: begin
        if (rdy_z_buffer && any_fill) begin
          gid_nxt  = sel;
          tcnt_nxt = '0;
          req_nxt  = {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
        end
      end
      S_SEND: begin
        if (ack_g) begin
          pix_nxt  = pix_in[int'(grant_id)*PIXEL_WIDTH +: PIXEL_WIDTH];
          req_nxt  = '0;
          send_nxt = 1'b1;
`ifdef CT_RR_TIEBREAK_EN
          last_nxt = grant_id;
`endif
        end else if (timeout_hit) begin
          req_nxt  = '0;
          tcnt_nxt = '0;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (!rdy_z_buffer) begin
          send_nxt = 1'b0;
          pix_nxt  = '0;
        end
      end
      default: begin
        req_nxt  = '0;
        send_nxt = 1'b0;
        pix_nxt  = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/contention_arbiter_n.md
Name: contention_arbiter_n

Overview:
- N-channel successor of the 4-input contention tree.
- Selects the input FIFO with the highest fill level and requests one pixel from it over a req/ack handshake.
- Forwards that pixel to the Z-buffer over a send/rdy handshake.
- Sits between the per-rasteriser pixel FIFOs and the single Z-buffer write port.
- Adds over the previous generation:
  - parametrised channel count and widths
  - fully registered, reset-defined outputs
  - an exported grant index
  - an ack timeout that recovers from a silent channel

Parameters:
- NUM_CH, 4: number of input channels, 2..16.
- FILL_WIDTH, 8: width of each fill-level input.
- PIXEL_WIDTH, 8: width of each pixel word.
- TIMEOUT_CYCLES, 16: cycles in SEND without ack before abandoning the grant; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset asserted.
- pix_in  in  NUM_CH*PIXEL_WIDTH  pixel words; channel i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- fill  in  NUM_CH*FILL_WIDTH  FIFO fill levels; channel i occupies bits [i*FILL_WIDTH +: FILL_WIDTH], unsigned.
- ack  in  NUM_CH  per-channel acknowledge; pix_in slice is valid while ack is high.
- rdy_z_buffer  in  1  Z-buffer ready / transaction open.
- req  out  NUM_CH  one-hot request to the granted channel.
- send_z_buffer  out  1  pix_out valid to the Z-buffer.
- pix_out  out  PIXEL_WIDTH  forwarded pixel.
- grant_id  out  $clog2(NUM_CH)  index of the current or last granted channel.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; req=0, send_z_buffer=0, pix_out=0, grant_id=0, timeout counter=0.
  - Reset mid-transaction aborts it immediately; no partial pixel is emitted.
- All outputs are registered:
  - no tri-state
  - pix_out holds 0 whenever send_z_buffer=0
- FSM states: IDLE, HARVEST, SEND, WAIT.
- IDLE:
  - if rdy_z_buffer=1 -> HARVEST, else stay.
- HARVEST:
  - if rdy_z_buffer=0 -> IDLE.
  - else if all fill==0 -> stay.
  - else pick the channel g with the maximum fill; ties go to the lowest index.
  - Load grant_id=g, clear the timeout counter, -> SEND.
  - req[g]=1 from the first cycle in SEND.
- SEND:
  - req[g] is held high.
  - Only ack[g] is sampled; ack on any other channel is ignored.
  - On ack[g]=1: latch pix_out=pix_in slice g, then next cycle req=0, send_z_buffer=1, -> WAIT.
  - Latency from ack to send_z_buffer is 1 cycle.
  - Otherwise the timeout counter increments.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no ack: req=0, -> HARVEST. No pixel is emitted.
  - Simultaneous ack and timeout in the same cycle: the ack wins.
- WAIT:
  - send_z_buffer=1 and pix_out are held stable while rdy_z_buffer=1.
  - When rdy_z_buffer=0: next cycle send_z_buffer=0, pix_out=0, -> IDLE.
- Fill comparison is unsigned full-width.
- Fill values are sampled only in HARVEST; changes during SEND or WAIT do not alter the grant.
- At most one req bit is ever high.
- grant_id keeps its last value outside SEND and WAIT.

Optional Feature:
- Macro CT_RR_TIEBREAK_EN.
- Defined:
  - Ties among the maximum-fill channels are broken round-robin.
  - Priority starts at (last_served+1) mod NUM_CH.
  - last_served updates only on a completed transfer (ack received), not on a timeout.
  - last_served resets to NUM_CH-1, so the first tie picks channel 0.
- Undefined: fixed lowest-index tie-break, and no last_served register.

Test Plan (NUM_CH=4, PIXEL_WIDTH=8, TIMEOUT_CYCLES=16):
- reset=0 for 2 cycles with all inputs randomised -> req=0000, send_z_buffer=0, pix_out=0x00, grant_id=0.
- rdy_z_buffer=1, fill={ch0..3}={3,9,5,9}, ack[1] one cycle after req[1], pix_in ch1=0xA5 -> req=0010, then next cycle send_z_buffer=1, pix_out=0xA5; after rdy_z_buffer=0, IDLE with outputs 0.
- Repeat an all-equal fill {4,4,4,4} for 4 transactions, macro defined -> grants 0,1,2,3; macro undefined -> grants 0,0,0,0.
- Grant ch2 and never assert ack[2] -> req[2] drops after 16 SEND cycles, FSM returns to HARVEST, send_z_buffer stays 0; with fill unchanged, ch2 is regranted.
- During SEND on ch1, pulse ack[0] and ack[3] -> ignored, req stays 0010; a later ack[1] completes normally.
- Assert reset=0 in WAIT with send_z_buffer=1 -> next cycle send_z_buffer=0, pix_out=0, state IDLE; all fill=0 with rdy_z_buffer=1 -> stays in HARVEST, req=0000.
